dcache_axi_bridge: RTL and testbench

DCACHE_AXI_BRIDGE -- requirements
Module: dcache_axi_bridge

---
 rtl/dcache_axi_bridge.sv | 187 ++++++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_bridge.sv
// Data-cache bridge: turns single-beat writes and line-fill reads into AXI4 transactions.
// One request in flight at a time; responses stream back without backpressure.
module dcache_axi_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                rsp_valid,
    output logic                rsp_last,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,

    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [3:0]          awcache,
    output logic                awvalid,
    input  logic                awready,

    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,

    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [3:0]          arcache,
    output logic                arvalid,
    input  logic                arready,

    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * BYTES - 1);
    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, AR, RD, AW_W, BR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [BYTES-1:0]    cap_wstrb;
    logic                aw_done;
    logic                w_done;
    logic [7:0]          beat_cnt;
    logic                err_acc;

    // Only the SLVERR/DECERR bit of a response matters; EXOKAY vs OKAY is irrelevant here.
    logic                unused_resp;
    assign unused_resp = ^{bresp[0], rresp[0]};

    // NOTE: combinational process uses blocking '=' and assigns every output a default
    // first, so no path through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_we ? AW_W : AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD;
            end
            RD: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nxt = IDLE;
            end
            AW_W: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = BR;
            end
            BR: begin
                bready = 1'b1;
                if (bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential processes use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the captured payload is left out of reset; it is always loaded before it is driven out.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            beat_cnt  <= '0;
            err_acc   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            if (req_valid && req_ready) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (rvalid && rready) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata;
                if (rlast) begin
                    rsp_last <= 1'b1;
                    rsp_err  <= err_acc | rresp[1] | (beat_cnt != LAST_IDX);
                    beat_cnt <= '0;
                    err_acc  <= 1'b0;
                end else begin
                    // A non-last beat at or past the line end means the burst overran.
                    beat_cnt <= beat_cnt + 8'd1;
                    err_acc  <= err_acc | rresp[1] | (beat_cnt >= LAST_IDX);
                end
            end
            if (bvalid && bready) begin
                rsp_valid <= 1'b1;
                rsp_last  <= 1'b1;
                rsp_err   <= bresp[1];
                rsp_rdata <= '0;
            end
        end
    end

    assign araddr  = cap_addr & ~LINE_MASK;
    assign arlen   = LAST_IDX;
    assign arsize  = 3'(SIZE);
    assign arburst = 2'b01;
    assign arcache = 4'b0011;

    assign awaddr  = cap_addr;
    assign awlen   = 8'd0;
    assign awsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign awcache = 4'b0011;

    assign wdata   = cap_wdata;
    assign wstrb   = wvalid ? cap_wstrb : '0;
    assign wlast   = wvalid;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: directed vector table, hand-written reset
// and stray-input sequences, then randomized transactions against a response model.
module tb_dcache_axi_bridge;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 4;
    localparam logic [31:0] LINE_BYTES_M1 = 32'(BURST_LEN * DATA_W / 8 - 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [3:0]  awcache, arcache, wstrb;
    logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    dcache_axi_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, b_dly, ar_dly;
        logic [1:0]  bresp;
        int          nbeats;
        bit          r_gap;  // random idle cycles between read beats
        bit          stray;  // drive the unused response channel throughout
        bit          poke;   // hold a second request while busy
    } txn_t;

    typedef struct {
        txn_t        t;
        int          bad_beat;
        logic [1:0]  bad_resp;
        logic [31:0] exp_addr;
        int          exp_nrsp;
        bit          exp_err;
    } vec_t;

    rsp_t        rsp_q[$];
    rsp_t        exp_q[$];
    logic [31:0] beat_data[16];
    logic [1:0]  beat_resp[16];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_q.push_back('{rsp_rdata, rsp_last, rsp_err, cyc});
    end

    // Response model: a write gives one final response carrying bresp[1]; a read gives one
    // response per delivered beat, the last one flagged and erroring on any SLVERR/DECERR
    // in the burst or on a beat count other than the line length.
    task automatic build_expect(input txn_t t);
        bit any_bad = 1'b0;
        bit last;
        exp_q.delete();
        if (t.we) begin
            exp_q.push_back('{32'h0, 1'b1, t.bresp[1], 0});
        end else begin
            for (int i = 0; i < t.nbeats; i++) any_bad |= beat_resp[i][1];
            for (int i = 0; i < t.nbeats; i++) begin
                last = (i == t.nbeats - 1);
                exp_q.push_back('{beat_data[i], last, last && (any_bad || t.nbeats != BURST_LEN), 0});
            end
        end
    endtask

    task automatic clear_slave();
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
        bvalid = 0; bresp = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0;
        clear_slave();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Acts as the AXI slave for one request, checking channel signals every cycle and
    // then comparing the collected responses against the model.
    task automatic run_txn(input txn_t t, input logic [31:0] exp_addr);
        bit ar_done = 0, aw_done = 0, w_done = 0, fin = 0;
        bit hs_ar, hs_aw, hs_w, hs_r, hs_rl, hs_b, fast;
        int ar_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0, sent = 0, acc_cyc, n = 0;
        rsp_q.delete();
        build_expect(t);
        req_valid = 1; req_we = t.we; req_addr = t.addr; req_wdata = t.wdata; req_wstrb = t.wstrb;
        check("req_ready_idle", req_ready, 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = t.poke; req_we = ~t.we; req_addr = ~t.addr;
        req_wdata = ~t.wdata; req_wstrb = ~t.wstrb;
        while (!fin && n < 100) begin
            n++;
            if (t.poke) check("busy_req_ready", req_ready, 0);
            clear_slave();
            if (t.we) begin
                awready = awvalid && (aw_wait >= t.aw_dly);
                wready  = wvalid && (w_wait >= t.w_dly);
                bvalid  = aw_done && w_done && (b_wait >= t.b_dly);
                bresp   = t.bresp;
                if (t.stray) begin rvalid = 1; rlast = 1; rdata = 32'hBAD0_BAD0; end
                check("awvalid", awvalid, !aw_done);
                check("wvalid", wvalid, !w_done);
                check("bready", bready, aw_done && w_done);
                check("wstrb", wstrb, wvalid ? t.wstrb : 4'h0);
                if (awvalid) begin
                    check("awaddr", awaddr, exp_addr);
                    check("aw_attr", {awlen, awsize, awburst, awcache}, {8'd0, 3'd2, 2'b01, 4'b0011});
                end
                if (wvalid) begin
                    check("wdata", wdata, t.wdata);
                    check("wlast", wlast, 1);
                end
            end else begin
                arready = arvalid && (ar_wait >= t.ar_dly);
                if (ar_done && sent < t.nbeats && !(t.r_gap && $urandom_range(0, 2) == 0)) begin
                    rvalid = 1; rdata = beat_data[sent]; rresp = beat_resp[sent];
                    rlast = (sent == t.nbeats - 1);
                end
                if (t.stray) begin bvalid = 1; bresp = 2'b10; end
                check("arvalid", arvalid, !ar_done);
                check("rready", rready, ar_done);
                if (arvalid) begin
                    check("araddr", araddr, exp_addr);
                    check("ar_attr", {arlen, arsize, arburst, arcache},
                          {8'(BURST_LEN - 1), 3'd2, 2'b01, 4'b0011});
                end
            end
            hs_ar = arvalid && arready; hs_aw = awvalid && awready; hs_w = wvalid && wready;
            hs_r = rvalid && rready; hs_rl = hs_r && rlast; hs_b = bvalid && bready;
            @(posedge clk); #1;
            if (!ar_done && !hs_ar) ar_wait++;
            if (!aw_done && !hs_aw) aw_wait++;
            if (!w_done && !hs_w) w_wait++;
            if (aw_done && w_done && !hs_b) b_wait++;
            if (hs_ar) ar_done = 1;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            if (hs_r) sent++;
            if (hs_rl || hs_b) fin = 1;
        end
        req_valid = 0;
        clear_slave();
        if (!fin) begin
            check("txn_timeout", 0, 1);
            do_reset();
        end
        check("idle_after_txn", req_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_new_txn", {arvalid, awvalid, wvalid, rsp_valid}, 4'b0);
        end
        check("rsp_count", rsp_q.size(), exp_q.size());
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            check("rsp_rdata", rsp_q[i].data, exp_q[i].data);
            check("rsp_last", rsp_q[i].last, exp_q[i].last);
            check("rsp_err", rsp_q[i].err, exp_q[i].err);
        end
        fast = t.we ? (t.aw_dly == 0 && t.w_dly == 0 && t.b_dly == 0) : (t.ar_dly == 0 && !t.r_gap);
        if (fast && rsp_q.size() > 0) check("rsp_latency", rsp_q[0].cyc - acc_cyc, 3);
    endtask

    function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] ws, input int a_dly, input int w_dly,
                                input logic [1:0] br, input int nbeats, input int bad_beat,
                                input logic [1:0] bad_resp, input logic [31:0] exp_addr,
                                input int exp_nrsp, input bit exp_err);
        vec_t v;
        v.t = '{we, addr, wd, ws, we ? a_dly : 0, w_dly, 0, we ? 0 : a_dly, br, nbeats, 0, 0, 0};
        v.bad_beat = bad_beat; v.bad_resp = bad_resp;
        v.exp_addr = exp_addr; v.exp_nrsp = exp_nrsp; v.exp_err = exp_err;
        return v;
    endfunction

    localparam int NV = 10;
    vec_t vec[NV];

    initial begin
        txn_t rt;
        vec[0] = mk(0, 32'h0000_1014, 0, 0, 0, 0, 0, 4, -1, 2'b00, 32'h0000_1010, 4, 0);
        vec[1] = mk(1, 32'h2000_0008, 32'hDEAD_BEEF, 4'b0011, 2, 0, 2'b00, 0, -1, 0, 32'h2000_0008, 1, 0);
        vec[2] = mk(1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 0, 2'b10, 0, -1, 0, 32'h3000_0004, 1, 1);
        vec[3] = mk(0, 32'h4000_003C, 0, 0, 0, 0, 0, 2, -1, 2'b00, 32'h4000_0030, 2, 1);
        vec[4] = mk(0, 32'h5000_0000, 0, 0, 1, 0, 0, 4, 1, 2'b10, 32'h5000_0000, 4, 1);
        vec[5] = mk(0, 32'h6000_0008, 0, 0, 0, 0, 0, 4, 2, 2'b01, 32'h6000_0000, 4, 0);
        vec[6] = mk(1, 32'h7000_0010, 32'hCAFE_F00D, 4'b1100, 0, 3, 2'b01, 0, -1, 0, 32'h7000_0010, 1, 0);
        vec[7] = mk(0, 32'h8000_0004, 0, 0, 0, 0, 0, 5, -1, 2'b00, 32'h8000_0000, 5, 1);
        vec[8] = mk(0, 32'h9000_000F, 0, 0, 2, 0, 0, 1, -1, 2'b00, 32'h9000_0000, 1, 1);
        vec[9] = mk(1, 32'hA000_0000, 32'h0BAD_CAFE, 4'b0101, 1, 1, 2'b11, 0, -1, 0, 32'hA000_0000, 1, 1);
        vec[1].t.stray = 1;
        vec[3].t.poke  = 1;
        vec[5].t.stray = 1;
        vec[6].t.poke  = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("rst_readies", {bready, rready}, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_last, rsp_err}, 3'b000);
        check("rst_wstrb", wstrb, 4'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // Stray slave responses while idle produce nothing
        rvalid = 1; rlast = 1; bvalid = 1; bresp = 2'b10;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_stray_rsp", rsp_valid, 0);
        end
        clear_slave();

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) begin
                beat_data[i] = (32'(v + 1) << 24) | 32'(i * 16'h0101);
                beat_resp[i] = (i == vec[v].bad_beat) ? vec[v].bad_resp : 2'b00;
            end
            run_txn(vec[v].t, vec[v].exp_addr);
            check("vec_nrsp", rsp_q.size(), vec[v].exp_nrsp);
            if (rsp_q.size() > 0) check("vec_err", rsp_q[rsp_q.size() - 1].err, vec[v].exp_err);
        end

        // Reset during RD after the first beat
        req_valid = 1; req_we = 0; req_addr = 32'hB000_0020;
        @(posedge clk); #1;
        req_valid = 0; arready = 1;
        check("mid_rd_arvalid", arvalid, 1);
        @(posedge clk); #1;
        arready = 0;
        check("mid_rd_rready", rready, 1);
        rvalid = 1; rdata = 32'h1111_2222; rlast = 0;
        @(posedge clk); #1;
        check("mid_rd_beat1", rsp_valid, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check("mid_rd_rst_rready", rready, 0);
        check("mid_rd_rst_rsp", rsp_valid, 0);
        rst_n = 1; rvalid = 0;
        check("mid_rd_req_ready", req_ready, 1);
        @(posedge clk); #1;
        check("mid_rd_quiet", {rsp_valid, arvalid, rready}, 3'b000);

        // Reset during AW_W, then a late bvalid must not produce a response
        req_valid = 1; req_we = 1; req_addr = 32'hC000_0004; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        check("mid_wr_valids", {awvalid, wvalid}, 2'b11);
        check("mid_wr_wstrb", wstrb, 4'hF);
        rst_n = 0;
        @(posedge clk); #1;
        check("mid_wr_rst_valids", {awvalid, wvalid, bready}, 3'b000);
        check("mid_wr_rst_wstrb", wstrb, 4'h0);
        rst_n = 1; bvalid = 1; bresp = 2'b10;
        repeat (2) begin
            @(posedge clk); #1;
            check("mid_wr_no_rsp", rsp_valid, 0);
        end
        clear_slave();
        @(posedge clk); #1;

        // Randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            rt.we     = 1'($urandom_range(0, 1));
            rt.addr   = $urandom;
            rt.wdata  = $urandom;
            rt.wstrb  = 4'($urandom_range(0, 15));
            rt.aw_dly = $urandom_range(0, 3);
            rt.w_dly  = $urandom_range(0, 3);
            rt.b_dly  = $urandom_range(0, 3);
            rt.ar_dly = $urandom_range(0, 3);
            rt.bresp  = 2'($urandom_range(0, 3));
            rt.nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BURST_LEN + 1) : BURST_LEN;
            rt.r_gap  = 1'($urandom_range(0, 1));
            rt.stray  = 1'($urandom_range(0, 1));
            rt.poke   = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                beat_data[i] = $urandom;
                beat_resp[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            run_txn(rt, rt.we ? rt.addr : (rt.addr & ~LINE_BYTES_M1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
